// File: rtl/push_tx.sv
`default_nettype none
// ============================================================================
// Module   : push_tx
// Purpose  : Push-sequence generator driving a push counter's button lines.
//            On an accepted start it holds reg_en high and emits `count`
//            press/release pulses on button line `key_sel`, then pulses done.
// Ports    : clock        - system clock, rising edge
//            reset        - asynchronous, active-low
//            start        - burst request, accepted only while idle
//            count[3:0]   - presses requested, sampled on accept
//            key_sel      - button line to drive, sampled on accept
//            abort        - cut a running burst short (goes to DONE)
//            push_out     - press lines, one-hot on key_sel during a press
//            reg_en       - counter enable, high from setup to last gap
//            busy         - high whenever not idle
//            done         - one-cycle completion pulse
//            pushes_left  - presses not yet completed
//            ring_in/err  - echo compare of the counter's ring output
//                           (present only with PUSH_TX_ECHO_EN defined;
//                           the echo ring needs WIDTH >= 2)
// Revision : 1.0 - initial release
// ============================================================================
module push_tx #(
  parameter int WIDTH     = 8,
  parameter int PRESS_CYC = 2,
  parameter int GAP_CYC   = 3,
  localparam int SEL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       count,
  input  logic [SEL_W-1:0] key_sel,
  input  logic             abort,
`ifdef PUSH_TX_ECHO_EN
  input  logic [WIDTH-1:0] ring_in,
  output logic             err,
`endif
  output logic [WIDTH-1:0] push_out,
  output logic             reg_en,
  output logic             busy,
  output logic             done,
  output logic [3:0]       pushes_left
);

  // Phase counter only ever holds (cycles - 1) of the longer phase.
  localparam int CNT_MAX = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PRESS = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_key;
  logic             w_last;
  logic             w_accept;
  logic             w_press_done;
  logic [WIDTH-1:0] w_line;

  always_comb begin
    w_last       = (r_cnt == '0);
    w_accept     = (r_state == S_IDLE) && start;
    // A press counts as completed only if it is not cut by abort.
    w_press_done = (r_state == S_PRESS) && w_last && !abort;

    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (count != 4'd0) ? S_SETUP : S_DONE;
      S_SETUP: w_next = abort ? S_DONE : S_PRESS;
      S_PRESS: begin
        if (abort)       w_next = S_DONE;
        else if (w_last) w_next = S_GAP;
      end
      S_GAP: begin
        if (abort)       w_next = S_DONE;
        else if (w_last) w_next = (pushes_left != 4'd0) ? S_PRESS : S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // One-hot decode; an out-of-range key matches no line, so nothing is driven.
    w_line = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_line[i] = (r_key == i[SEL_W-1:0]);
    end
  end

  // Outputs are produced from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_key       <= '0;
      push_out    <= '0;
      reg_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pushes_left <= 4'd0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state) begin
        if (w_next == S_PRESS)    r_cnt <= CNT_W'(PRESS_CYC - 1);
        else if (w_next == S_GAP) r_cnt <= CNT_W'(GAP_CYC - 1);
        else                      r_cnt <= '0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_accept) begin
        r_key       <= key_sel;
        pushes_left <= count;
      end else if (w_press_done && (pushes_left != 4'd0)) begin
        pushes_left <= pushes_left - 4'd1;
      end

      push_out <= (w_next == S_PRESS) ? w_line : '0;
      reg_en   <= (w_next == S_SETUP) || (w_next == S_PRESS) || (w_next == S_GAP);
      busy     <= (w_next != S_IDLE);
      done     <= (w_next == S_DONE);
    end
  end

`ifdef PUSH_TX_ECHO_EN
  // Expected ring value of the counter; starts empty and seeds bit 0 on the
  // first completed press, then rotates once per completed press.
  logic [WIDTH-1:0] r_exp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_exp <= '0;
      err   <= 1'b0;
    end else if (w_accept) begin
      r_exp <= '0;
      err   <= 1'b0;
    end else begin
      if (w_press_done) begin
        r_exp <= {r_exp[WIDTH-2:0], r_exp[WIDTH-1] | (r_exp == '0)};
      end
      if ((r_state == S_GAP) && w_last && (ring_in != r_exp)) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_push_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_push_tx
// Purpose  : Self-checking bench for push_tx. A burst planner turns each
//            request into the per-cycle output trace it must produce; a
//            negedge process compares the DUT to that trace every cycle and
//            also runs a few hand-computed spot checks on recorded bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_push_tx;

  localparam int PC  = 2;
  localparam int GC  = 3;
  localparam int PER = PC + GC;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] count;
  logic [2:0] key_sel;
  logic       abort;
  logic [7:0] push_out;
  logic       reg_en;
  logic       busy;
  logic       done;
  logic [3:0] pushes_left;
`ifdef PUSH_TX_ECHO_EN
  logic [7:0] ring_in;
  logic       err;
`endif

  push_tx #(.WIDTH(8), .PRESS_CYC(PC), .GAP_CYC(GC)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .key_sel     (key_sel),
    .abort       (abort),
`ifdef PUSH_TX_ECHO_EN
    .ring_in     (ring_in),
    .err         (err),
`endif
    .push_out    (push_out),
    .reg_en      (reg_en),
    .busy        (busy),
    .done        (done),
    .pushes_left (pushes_left)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [7:0] push;
    logic       reg_en;
    logic       busy;
    logic       done;
    logic       err;
    int         left;
    int         t;
  } exp_t;

  // Expected trace: written by the stimulus (wr), consumed by the checker (rd).
  exp_t exp_a [0:1023];
  int   wr        = 0;
  int   rd        = 0;
  int   skip_upto = 0;
  int   held_left = 0;
  logic held_err  = 1'b0;
  int   lit_req   = 0;
  int   lit_ack   = 0;

  int   total = 0;
  int   bad   = 0;

  // Per-burst recording, indexed by cycle since accept.
  logic [7:0] s_push [0:63];
  logic       s_reg  [0:63];
  logic       s_done [0:63];
  logic       s_err  [0:63];
  int         s_left [0:63];
  int         s_n = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] line_of(int k);
    logic [7:0] one;
    one = 8'h01;
    return (k < 8) ? (one << k) : 8'h00;
  endfunction

  function automatic void put(logic [7:0] p, logic r, logic b, logic d, logic e, int l, int t);
    exp_a[wr].push   = p;
    exp_a[wr].reg_en = r;
    exp_a[wr].busy   = b;
    exp_a[wr].done   = d;
    exp_a[wr].err    = e;
    exp_a[wr].left   = l;
    exp_a[wr].t      = t;
    wr++;
  endfunction

  // Cycle t=0 is SETUP; press p covers t=1+p*PER..PC+p*PER, its gap the next
  // GC cycles. An abort seen during cycle t makes cycle t+1 the DONE cycle.
  function automatic void plan(int n, int k, int ab, bit bad_ring);
    int         last;
    int         p;
    int         ph;
    int         l;
    logic [7:0] pv;
    put(8'h00, 1'b0, 1'b0, 1'b0, held_err, held_left, -1);
    l = n;
    if (n == 0)                      last = -1;
    else if (ab >= 0 && ab <= PER*n) last = ab;
    else                             last = PER*n;
    for (int t = 0; t <= last; t++) begin
      if (t == 0) begin
        pv = 8'h00;
        l  = n;
      end else begin
        p  = (t - 1) / PER;
        ph = (t - 1) % PER;
        if (ph < PC) begin pv = line_of(k); l = n - p;     end
        else         begin pv = 8'h00;      l = n - p - 1; end
      end
      put(pv, 1'b1, 1'b1, 1'b0, 1'b0, l, t);
    end
    held_err  = bad_ring && (n > 0) && !(ab >= 0 && ab < PER*n);
    held_left = l;
    put(8'h00, 1'b0, 1'b1, 1'b1, held_err, l, last + 1);
  endfunction

  // Counter ring after the presses completed by cycle t; optionally wrong
  // (all zero) on the final gap's last cycle.
  function automatic logic [7:0] ring_for(int n, int t, bit bad_ring);
    int         pc;
    logic [7:0] one;
    one = 8'h01;
    if (bad_ring && n > 0 && t == PER*n) return 8'h00;
    pc = (t < PC + 1) ? 0 : (t - PC - 1) / PER + 1;
    if (pc > n) pc = n;
    return (pc == 0) ? 8'h00 : (one << ((pc - 1) % 8));
  endfunction

  function automatic void do_lit(int id);
    int nreg;
    int npress;
    int dix;
    nreg = 0; npress = 0; dix = -1;
    for (int t = 0; t < s_n; t++) begin
      if (s_reg[t]) nreg++;
      if (s_push[t] == 8'h04) npress++;
      if (s_done[t] && dix < 0) dix = t;
    end
    chk("drained", wr - rd, 0);
    case (id)
      1: begin
        chk("t1_busy", busy, 0);
        chk("t1_push", push_out, 0);
        chk("t1_reg_en", reg_en, 0);
        chk("t1_done", done, 0);
        chk("t1_left", pushes_left, 0);
      end
      2: begin
        chk("t2_reg_en_cycles", nreg, 16);
        chk("t2_done_cycle", dix + 1, 17);
        chk("t2_press_cycles", npress, 6);
        chk("t2_push_t1", s_push[1], 8'h04);
        chk("t2_push_t3", s_push[3], 8'h00);
        chk("t2_left_t0", s_left[0], 3);
        chk("t2_left_t3", s_left[3], 2);
        chk("t2_left_t8", s_left[8], 1);
        chk("t2_left_t13", s_left[13], 0);
      end
      3: begin
        chk("t3_done_t0", s_done[0], 1);
        chk("t3_reg_en_t0", s_reg[0], 0);
        chk("t3_push_t0", s_push[0], 0);
      end
      4: begin
        chk("t4_push_t6", s_push[6], 8'h20);
        chk("t4_done_cycle", dix, 7);
        chk("t4_push_t7", s_push[7], 8'h00);
        chk("t4_left_done", s_left[7], 4);
      end
      5: begin
        chk("t5_async_push", push_out, 0);
        chk("t5_async_reg_en", reg_en, 0);
        chk("t5_async_busy", busy, 0);
      end
      6: chk("t5_done_cycle", dix + 1, 7);
`ifdef PUSH_TX_ECHO_EN
      7: chk("t6_err_good", err, 0);
      8: chk("t6_err_bad", err, 1);
      9: begin
        chk("t6_err_cleared_t0", s_err[0], 0);
        chk("t6_err_after", err, 0);
      end
`endif
      default: ;
    endcase
  endfunction

  // Compare process: every cycle, DUT outputs versus the planned trace.
  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clock);
      if (rd < skip_upto) rd = skip_upto;
      if (rd < wr) begin
        e = exp_a[rd];
        rd++;
      end else begin
        e.push = 8'h00; e.reg_en = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        e.err = held_err; e.left = held_left; e.t = -1;
      end
      chk("push_out", push_out, e.push);
      chk("reg_en", reg_en, e.reg_en);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("pushes_left", pushes_left, e.left);
`ifdef PUSH_TX_ECHO_EN
      chk("err", err, e.err);
`endif
      if (e.t >= 0 && e.t < 64) begin
        if (e.t == 0) s_n = 0;
        s_push[e.t] = push_out;
        s_reg[e.t]  = reg_en;
        s_done[e.t] = done;
        s_left[e.t] = pushes_left;
`ifdef PUSH_TX_ECHO_EN
        s_err[e.t]  = err;
`else
        s_err[e.t]  = 1'b0;
`endif
        s_n = e.t + 1;
      end
      if (lit_req != lit_ack) begin
        do_lit(lit_req);
        lit_ack = lit_req;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lit(input int id);
    lit_req = id;
    @(negedge clock);
    #1;
  endtask

  // ab: cycle with abort (-1 none, -2 together with start); stray: cycle
  // with an extra start that must be ignored.
  task automatic run_burst(input int n, input int k, input int ab, input int stray, input bit bad_ring);
    int len;
    tick();
    start   = 1'b1;
    count   = 4'(n);
    key_sel = 3'(k);
    abort   = (ab == -2);
    plan(n, k, ab, bad_ring);
    if (n == 0)                     len = 1;
    else if (ab >= 0 && ab < PER*n) len = ab + 2;
    else                            len = PER*n + 2;
    for (int t = 0; t <= len; t++) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (t == ab) abort = 1'b1;
      if (t == stray) begin start = 1'b1; count = 4'd9; end
`ifdef PUSH_TX_ECHO_EN
      ring_in = ring_for(n, t, bad_ring);
`endif
    end
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1; start = 1'b0; abort = 1'b0; count = 4'd0; key_sel = 3'd0;
`ifdef PUSH_TX_ECHO_EN
    ring_in = 8'h00;
`endif
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    lit(1);

    run_burst(3, 2, -1, -1, 1'b0);  lit(2);
    run_burst(0, 1, -1, -1, 1'b0);  lit(3);
    run_burst(5, 5, 6, 3, 1'b0);    lit(4);
    run_burst(2, 3, -2, -1, 1'b0);          // start and abort together
    run_burst(1, 6, PER + 1, -1, 1'b0);     // abort during DONE
    tick(); abort = 1'b1; tick(); abort = 1'b0;  // abort while idle
    repeat (2) tick();

    // Reset dropped mid-gap of a count=2 burst.
    tick();
    start = 1'b1; count = 4'd2; key_sel = 3'd0;
    plan(2, 0, -1, 1'b0);
    tick();
    start = 1'b0;
    repeat (3) tick();
    #1;
    reset = 1'b0;
    skip_upto = wr;
    held_left = 0;
    held_err  = 1'b0;
    lit(5);
    tick(); tick();
    reset = 1'b1;
    run_burst(1, 7, -1, -1, 1'b0);  lit(6);

`ifdef PUSH_TX_ECHO_EN
    run_burst(3, 1, -1, -1, 1'b0);  lit(7);
    run_burst(3, 1, -1, -1, 1'b1);  lit(8);
    repeat (3) tick();
    run_burst(1, 0, -1, -1, 1'b0);  lit(9);
`endif

    repeat (2) tick();
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
